// File: rtl/z_n_seq_sub_if.sv
// Start/done handshake bundle for the sequential chunked subtractor.
// The sequencer (master) drives the request and operands; the subtractor
// (slave) returns the registered result, flags and status.
interface z_n_seq_sub_if #(
    parameter int n = 32
);
    logic         start;
    logic [n-1:0] a;
    logic [n-1:0] b;
    logic         b_in;
    logic [n-1:0] diff;
    logic         b_out;
    logic         ovf;
    logic         busy;
    logic         done;

    modport master (
        output start, a, b, b_in,
        input  diff, b_out, ovf, busy, done
    );

    modport slave (
        input  start, a, b, b_in,
        output diff, b_out, ovf, busy, done
    );
endinterface

// File: rtl/z_n_seq_sub.sv
// Multi-cycle n-bit subtractor (n = k*m): diff = a - b - b_in mod 2^n.
// One m-bit chunk is processed per clock, least significant chunk first,
// as a + ~b + carry, where the initial carry is the inverted borrow-in and
// the final borrow is the inverted carry out of the top chunk.
// Operands are captured when a request is accepted, so the requester may
// change them freely afterwards. Result and flags are only updated at the
// completing edge and held otherwise.
module z_n_seq_sub #(
    parameter int k = 8,
    parameter int m = 4
) (
    input  logic           clk,
    input  logic           rst,
    z_n_seq_sub_if.slave   bus
);

    localparam int n  = k * m;
    localparam int CW = (k > 1) ? $clog2(k) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(k - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q;
    logic [n-1:0]    aOp_q;
    logic [n-1:0]    bOp_q;
    logic [n-1:0]    partial_q;
    logic [n-1:0]    diff_q;
    logic [CW-1:0]   cnt_q;
    logic            carry_q;
    logic            bOut_q;
    logic            ovf_q;
    logic            busy_q;
    logic            done_q;

    logic [m-1:0]    aChunk;
    logic [m-1:0]    bChunk;
    logic [m:0]      chunkSum;
    logic [n-1:0]    partial_d;
    logic            ovf_d;

    // Select the operand chunk addressed by the counter and add it with the
    // running carry; the m+1 bit sum keeps the chunk carry-out in its MSB.
    always_comb begin
        aChunk = '0;
        bChunk = '0;
        for (int i = 0; i < k; i++) begin
            if (cnt_q == CW'(i)) begin
                aChunk = aOp_q[i*m +: m];
                bChunk = bOp_q[i*m +: m];
            end
        end
        chunkSum = {1'b0, aChunk} + {1'b0, ~bChunk} + {{m{1'b0}}, carry_q};
    end

    // Merge the fresh chunk sum into the partial result so the completing
    // edge can publish the full difference, including the last chunk.
    always_comb begin
        partial_d = partial_q;
        for (int i = 0; i < k; i++) begin
            if (cnt_q == CW'(i)) begin
                partial_d[i*m +: m] = chunkSum[m-1:0];
            end
        end
        ovf_d = (aOp_q[n-1] ^ bOp_q[n-1]) & (aOp_q[n-1] ^ partial_d[n-1]);
    end

    // Control FSM with registered result, flags, busy and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            aOp_q     <= '0;
            bOp_q     <= '0;
            partial_q <= '0;
            diff_q    <= '0;
            cnt_q     <= '0;
            carry_q   <= 1'b0;
            bOut_q    <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (bus.start) begin
                        aOp_q     <= bus.a;
                        bOp_q     <= bus.b;
                        carry_q   <= ~bus.b_in;
                        cnt_q     <= '0;
                        partial_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                RUN: begin
                    partial_q <= partial_d;
                    carry_q   <= chunkSum[m];
                    if (cnt_q == LAST_CNT) begin
                        diff_q  <= partial_d;
                        bOut_q  <= ~chunkSum[m];
                        ovf_q   <= ovf_d;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.diff  = diff_q;
    assign bus.b_out = bOut_q;
    assign bus.ovf   = ovf_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;

endmodule

// File: tb/tb_z_n_seq_sub.sv
// Directed and randomised checks of the chunked subtractor in three
// geometries: k=8/m=4 (32 bit), k=1/m=8 (8 bit) and k=3/m=5 (15 bit).
module tb_z_n_seq_sub;

    logic clk = 1'b0;
    logic rst;

    int testsRun    = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    z_n_seq_sub_if #(.n(32)) bus8 ();
    z_n_seq_sub_if #(.n(8))  busK1 ();
    z_n_seq_sub_if #(.n(15)) busK3 ();

    z_n_seq_sub #(.k(8), .m(4)) dutMain (.clk(clk), .rst(rst), .bus(bus8.slave));
    z_n_seq_sub #(.k(1), .m(8)) dutK1   (.clk(clk), .rst(rst), .bus(busK1.slave));
    z_n_seq_sub #(.k(3), .m(5)) dutK3   (.clk(clk), .rst(rst), .bus(busK3.slave));

    localparam logic [31:0] VEC_A  [6] = '{32'h0000_0010, 32'h0000_0000, 32'h8000_0000,
                                           32'h0000_0005, 32'h7FFF_FFFF, 32'h1234_5678};
    localparam logic [31:0] VEC_B  [6] = '{32'h0000_0001, 32'h0000_0001, 32'h0000_0001,
                                           32'h0000_0005, 32'hFFFF_FFFF, 32'h0123_4567};
    localparam logic        VEC_BI [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam logic [31:0] EXP_D  [6] = '{32'h0000_000F, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                                           32'hFFFF_FFFF, 32'h8000_0000, 32'h1111_1110};
    localparam logic        EXP_B  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic        EXP_O  [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

    // Issue one request on the 32-bit unit and count edges from the
    // accepting edge until done is seen (bounded).
    task automatic runMain(input logic [31:0] av, input logic [31:0] bv,
                           input logic bi, output int lat);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = av;
        bus8.b     = bv;
        bus8.b_in  = bi;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a     = 32'($urandom);
        bus8.b     = 32'($urandom);
        bus8.b_in  = 1'($urandom);
        lat = 0;
        while (bus8.done !== 1'b1 && lat < 40) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        testsRun += 5;
        if (bus8.diff !== 32'h0) begin
            testsFailed++; $display("[TB] FAIL reset_diff: got %h expected %h", bus8.diff, 32'h0);
        end
        if (bus8.b_out !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_bout: got %b expected 0", bus8.b_out);
        end
        if (bus8.ovf !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_ovf: got %b expected 0", bus8.ovf);
        end
        if (bus8.busy !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", bus8.busy);
        end
        if (bus8.done !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL reset_done: got %b expected 0", bus8.done);
        end
        rst = 1'b0;
    endtask

    task automatic test_subtract();
        int lat;
        for (int v = 0; v < 6; v++) begin
            runMain(VEC_A[v], VEC_B[v], VEC_BI[v], lat);
            testsRun += 5;
            if (lat != 8) begin
                testsFailed++; $display("[TB] FAIL sub%0d_latency: got %0d expected 8", v, lat);
            end
            if (bus8.diff !== EXP_D[v]) begin
                testsFailed++; $display("[TB] FAIL sub%0d_diff: got %h expected %h", v, bus8.diff, EXP_D[v]);
            end
            if (bus8.b_out !== EXP_B[v]) begin
                testsFailed++; $display("[TB] FAIL sub%0d_bout: got %b expected %b", v, bus8.b_out, EXP_B[v]);
            end
            if (bus8.ovf !== EXP_O[v]) begin
                testsFailed++; $display("[TB] FAIL sub%0d_ovf: got %b expected %b", v, bus8.ovf, EXP_O[v]);
            end
            if (bus8.busy !== 1'b0) begin
                testsFailed++; $display("[TB] FAIL sub%0d_busy_with_done: got %b expected 0", v, bus8.busy);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        bit sawDone = 1'b0;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 32'h0000_0100;
        bus8.b     = 32'h0000_0001;
        bus8.b_in  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        testsRun += 5;
        if (bus8.diff !== 32'h0) begin
            testsFailed++; $display("[TB] FAIL abort_diff: got %h expected %h", bus8.diff, 32'h0);
        end
        if (bus8.b_out !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL abort_bout: got %b expected 0", bus8.b_out);
        end
        if (bus8.ovf !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL abort_ovf: got %b expected 0", bus8.ovf);
        end
        if (bus8.busy !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL abort_busy: got %b expected 0", bus8.busy);
        end
        if (bus8.done !== 1'b0) begin
            testsFailed++; $display("[TB] FAIL abort_done: got %b expected 0", bus8.done);
        end
        rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) sawDone = 1'b1;
        end
        testsRun++;
        if (sawDone) begin
            testsFailed++; $display("[TB] FAIL abort_no_done: got activity after reset expected none");
        end
    endtask

    task automatic test_back_to_back();
        int edgeCnt;
        bit overlap = 1'b0;
        bit held    = 1'b1;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a     = 32'h0000_0100;
        bus8.b     = 32'h0000_0020;
        bus8.b_in  = 1'b0;
        @(posedge clk);
        edgeCnt = 0;
        forever begin
            @(negedge clk);
            if (bus8.done === 1'b1 || edgeCnt >= 40) break;
            if (bus8.busy !== 1'b1) overlap = 1'b1;
            if (edgeCnt + 1 == 3 || edgeCnt + 1 == 5) begin
                bus8.start = 1'b1;
                bus8.a     = 32'h0000_FFFF;
                bus8.b     = 32'h0000_0000;
                bus8.b_in  = 1'b0;
            end else begin
                bus8.start = 1'b0;
            end
            @(posedge clk);
            edgeCnt++;
        end
        testsRun += 2;
        if (edgeCnt != 8) begin
            testsFailed++; $display("[TB] FAIL ignore_latency: got %0d expected 8", edgeCnt);
        end
        if (bus8.diff !== 32'h0000_00E0) begin
            testsFailed++; $display("[TB] FAIL ignore_diff: got %h expected %h", bus8.diff, 32'h0000_00E0);
        end
        bus8.start = 1'b1;
        bus8.a     = 32'h0000_1234;
        bus8.b     = 32'h0000_0034;
        bus8.b_in  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus8.start = 1'b0;
        edgeCnt = 0;
        while (bus8.done !== 1'b1 && edgeCnt < 40) begin
            if (bus8.busy !== 1'b1) overlap = 1'b1;
            if (bus8.diff !== 32'h0000_00E0) held = 1'b0;
            @(posedge clk);
            edgeCnt++;
            @(negedge clk);
        end
        if (bus8.busy === 1'b1) overlap = 1'b1;
        testsRun += 4;
        if (edgeCnt != 8) begin
            testsFailed++; $display("[TB] FAIL b2b_latency: got %0d expected 8", edgeCnt);
        end
        if (bus8.diff !== 32'h0000_11FF) begin
            testsFailed++; $display("[TB] FAIL b2b_diff: got %h expected %h", bus8.diff, 32'h0000_11FF);
        end
        if (overlap) begin
            testsFailed++; $display("[TB] FAIL b2b_busy: got wrong busy level expected busy only while running");
        end
        if (!held) begin
            testsFailed++; $display("[TB] FAIL b2b_hold: got diff change during run expected %h held", 32'h0000_00E0);
        end
    endtask

    task automatic test_random_k1();
        logic [7:0] av, bv, expD, prevD;
        logic       bi, expB, expO;
        logic [8:0] ref9;
        int         lat, errs;
        bit         held;
        prevD = 8'h0;
        errs  = 0;
        for (int it = 0; it < 1000; it++) begin
            av = 8'($urandom); bv = 8'($urandom); bi = 1'($urandom);
            ref9 = {1'b0, av} - {1'b0, bv} - {8'h0, bi};
            expD = ref9[7:0];
            expB = ref9[8];
            expO = (av[7] ^ bv[7]) & (av[7] ^ ref9[7]);
            @(negedge clk);
            busK1.start = 1'b1; busK1.a = av; busK1.b = bv; busK1.b_in = bi;
            held = (busK1.diff === prevD);
            @(posedge clk);
            @(negedge clk);
            busK1.start = 1'b0;
            lat = 0;
            while (busK1.done !== 1'b1 && lat < 10) begin
                if (busK1.diff !== prevD) held = 1'b0;
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            testsRun += 5;
            if (lat != 1) begin
                testsFailed++; errs++;
                if (errs < 10) $display("[TB] FAIL k1_latency: got %0d expected 1", lat);
            end
            if (busK1.diff !== expD) begin
                testsFailed++; errs++;
                if (errs < 10) $display("[TB] FAIL k1_diff: %h-%h-%b got %h expected %h", av, bv, bi, busK1.diff, expD);
            end
            if (busK1.b_out !== expB) begin
                testsFailed++; errs++;
                if (errs < 10) $display("[TB] FAIL k1_bout: %h-%h-%b got %b expected %b", av, bv, bi, busK1.b_out, expB);
            end
            if (busK1.ovf !== expO) begin
                testsFailed++; errs++;
                if (errs < 10) $display("[TB] FAIL k1_ovf: %h-%h-%b got %b expected %b", av, bv, bi, busK1.ovf, expO);
            end
            if (!held) begin
                testsFailed++; errs++;
                if (errs < 10) $display("[TB] FAIL k1_hold: got diff change before done expected %h held", prevD);
            end
            prevD = expD;
        end
    endtask

    task automatic test_random_k3();
        logic [14:0] av, bv, expD, prevD;
        logic        bi, expB, expO;
        logic [15:0] ref16;
        int          lat, errs;
        bit          held;
        prevD = 15'h0;
        errs  = 0;
        for (int it = 0; it < 1000; it++) begin
            av = 15'($urandom); bv = 15'($urandom); bi = 1'($urandom);
            ref16 = {1'b0, av} - {1'b0, bv} - {15'h0, bi};
            expD  = ref16[14:0];
            expB  = ref16[15];
            expO  = (av[14] ^ bv[14]) & (av[14] ^ ref16[14]);
            @(negedge clk);
            busK3.start = 1'b1; busK3.a = av; busK3.b = bv; busK3.b_in = bi;
            held = (busK3.diff === prevD);
            @(posedge clk);
            @(negedge clk);
            busK3.start = 1'b0;
            busK3.a = 15'($urandom); busK3.b = 15'($urandom);
            lat = 0;
            while (busK3.done !== 1'b1 && lat < 10) begin
                if (busK3.diff !== prevD) held = 1'b0;
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            testsRun += 5;
            if (lat != 3) begin
                testsFailed++; errs++;
                if (errs < 10) $display("[TB] FAIL k3_latency: got %0d expected 3", lat);
            end
            if (busK3.diff !== expD) begin
                testsFailed++; errs++;
                if (errs < 10) $display("[TB] FAIL k3_diff: %h-%h-%b got %h expected %h", av, bv, bi, busK3.diff, expD);
            end
            if (busK3.b_out !== expB) begin
                testsFailed++; errs++;
                if (errs < 10) $display("[TB] FAIL k3_bout: %h-%h-%b got %b expected %b", av, bv, bi, busK3.b_out, expB);
            end
            if (busK3.ovf !== expO) begin
                testsFailed++; errs++;
                if (errs < 10) $display("[TB] FAIL k3_ovf: %h-%h-%b got %b expected %b", av, bv, bi, busK3.ovf, expO);
            end
            if (!held) begin
                testsFailed++; errs++;
                if (errs < 10) $display("[TB] FAIL k3_hold: got diff change before done expected %h held", prevD);
            end
            prevD = expD;
        end
    endtask

    initial begin
        rst = 1'b1;
        bus8.start  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.b_in  = 1'b0;
        busK1.start = 1'b0; busK1.a = '0; busK1.b = '0; busK1.b_in = 1'b0;
        busK3.start = 1'b0; busK3.a = '0; busK3.b = '0; busK3.b_in = 1'b0;
        test_reset();
        test_subtract();
        test_reset_mid_run();
        test_back_to_back();
        test_random_k1();
        test_random_k3();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
